sagu_miss_sched: RTL
====================

// Module: sagu_miss_sched
// PURPOSE
// Store-AGU TLB-miss scheduler. Captures stores the store AGU reports as tlbMiss,
// requests a page walk per distinct page (oldest first), and replays resolved ops
// back into the AGU through its mex_en/mex_addr/mex_attr port. It owns the AGU
// input slot during replay by holding normal issue; flushes on exception.
// PARAMETERS
// DEPTH      4    miss-buffer entries (power of 2, >=2)
// TIMEOUT    255  WALK_WAIT cycles before walk_req is re-issued
// PORTS
// clk          in   1   clock
// rst          in   1   reset, asynchronous, active-low
// except       in   1   pipeline flush; discards all buffered misses
// miss_en      in   1   AGU tlbMiss pulse for the op in its stage 1
// miss_addr    in   44  virtual address of missed op (cmplxAddr[43:0])
// miss_attr    in   4   attr of missed op
// miss_thread  in   1   thread of missed op
// walk_req     out  1   page-walk request, level until walk_ack
// walk_page    out  31  virtual page, addr[43:13], of head unresolved entry
// walk_thread  out  1   thread of walk request
// walk_ack     in   1   walker accepted request
// walk_done    in   1   walk finished (TLB refilled or fault recorded)
// issue_hold   out  1   block normal AGU issue (read_clkEn) next cycle
// mex_en       out  1   replay valid into AGU
// mex_addr     out  44  replay address
// mex_attr     out  4   replay attr
// full         out  1   count >= DEPTH-1; issue must stall new stores
// overflow     out  1   one-cycle pulse: miss dropped because buffer full
// busy         out  1   FSM not IDLE or any entry valid
// BEHAVIOUR
// - Reset: all outputs 0, all entries invalid, FSM=IDLE, timeout counter 0.
// - Entry: {valid, resolved, addr[43:0], attr[3:0], thread}; circular FIFO,
//   head/tail pointers log2(DEPTH)+1 bits (wrap bit distinguishes full/empty).
// - Capture: miss_en & ~except & count<DEPTH -> write at tail, resolved=0.
//   miss_en & count==DEPTH -> drop, overflow=1 next cycle. except beats miss_en.
// - FSM IDLE: head valid & ~resolved -> WALK_REQ; head valid & resolved -> HOLD.
// - WALK_REQ: walk_req=1, walk_page=head.addr[43:13]; walk_ack -> WALK_WAIT,
//   counter cleared.
// - WALK_WAIT: counter++ each cycle; walk_done -> set resolved on EVERY valid entry
//   whose addr[43:13] and thread match walk_page/walk_thread (same-cycle capture
//   matching also sets resolved) -> HOLD. counter==TIMEOUT -> WALK_REQ (re-issue).
// - HOLD: issue_hold=1 for exactly one cycle -> REPLAY.
// - REPLAY: issue_hold stays 1; mex_en=1 with head addr/attr; pop head. If next head
//   valid & resolved, replay it next cycle (one per cycle); else -> IDLE and
//   issue_hold drops. Replay latency walk_done -> first mex_en = 2 cycles.
// - Fault walks still resolve; AGU reports pageFault on replay, not this block.
// - except (any state): all entries invalidated, head=tail, mex_en/issue_hold 0
//   next cycle. In WALK_REQ/IDLE/HOLD/REPLAY -> IDLE. In WALK_WAIT -> DRAIN:
//   wait walk_done (no entries marked) then IDLE; new misses captured during DRAIN
//   but not walked until IDLE. walk_req with walk_ack pending at except: the
//   walker has already latched, so WALK_REQ & walk_ack same cycle as except -> DRAIN.
// - Replayed op that misses again is re-captured at tail like a new miss.
// - full and busy combinational from registered state; all others registered.
// STRUCTURE
// - Shared header (struct.sv): state encoding localparams (IDLE, WALK_REQ,
//   WALK_WAIT, HOLD, REPLAY, DRAIN) and entry field width/offset defines.
// - Sub-module sagu_miss_buf: DEPTH-entry FIFO storage plus page/thread match
//   vector for resolve-marking; FSM, timeout counter and outputs stay in top.
// TESTING
// - Single miss addr=0x0000_0012_3440, walk_ack +1, walk_done +5 -> mex_en
//   2 cycles after walk_done with same addr, issue_hold high 2 cycles, busy low after.
// - 3 misses, pages A,B,A: one walk for A; walk_done -> replays entries 0 and 2?
//   No: in order, entry0 replayed, entry1 unresolved stops replay, walk B, then
//   entries 1,2 replayed back-to-back; exactly 2 walk_req handshakes total.
// - Fill DEPTH=4: full high at count 3, 5th miss -> overflow pulse, entry dropped.
// - No walk_done for 255 cycles -> walk_req re-asserted same page; then done
//   -> normal replay.
// - except during WALK_WAIT -> entries cleared, DRAIN until walk_done, no mex_en;
//   except with miss_en same cycle -> nothing captured.
// - rst asserted mid-REPLAY -> all outputs 0 immediately, no further mex_en.

Source files
------------

// File: rtl/sagu_miss_sched_pkg.sv
// Shared types for the store-AGU TLB-miss scheduler: FSM encoding, address/page
// geometry and the payload kept per buffered miss.
package sagu_miss_sched_pkg;

    localparam int ADDR_W   = 44;
    localparam int ATTR_W   = 4;
    localparam int PAGE_LSB = 13;
    localparam int PAGE_W   = ADDR_W - PAGE_LSB;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WALK_REQ  = 3'd1,
        S_WALK_WAIT = 3'd2,
        S_HOLD      = 3'd3,
        S_REPLAY    = 3'd4,
        S_DRAIN     = 3'd5
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ATTR_W-1:0] attr;
        logic              thread;
    } miss_data_t;

endpackage

// File: rtl/sagu_miss_buf.sv
// Circular miss buffer: in-order capture/pop, flush, and a page/thread match
// vector that marks every waiting entry covered by a finished walk.
module sagu_miss_buf
    import sagu_miss_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_wr_en,
    input  miss_data_t             i_wr_data,
    input  logic                   i_pop,
    input  logic                   i_mark_en,
    input  logic [PAGE_W-1:0]      i_mark_page,
    input  logic                   i_mark_thread,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_any_valid,
    output logic                   o_head_valid,
    output logic                   o_head_resolved,
    output miss_data_t             o_head,
    output logic                   o_next_valid,
    output logic                   o_next_resolved,
    output logic [ADDR_W-1:0]      o_next_addr,
    output logic [ATTR_W-1:0]      o_next_attr
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    miss_data_t       r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_resolved;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [DEPTH-1:0] w_match;
    logic [IDX_W-1:0] w_head_idx;
    logic [IDX_W-1:0] w_next_idx;
    logic [IDX_W-1:0] w_tail_idx;
    logic             w_wr_match;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_tail_idx = r_tail[IDX_W-1:0];
    assign w_next_idx = w_head_idx + IDX_W'(1);

    always_comb begin
        w_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = r_valid[i]
                      && (r_data[i].addr[ADDR_W-1:PAGE_LSB] == i_mark_page)
                      && (r_data[i].thread == i_mark_thread);
        end
    end

    // A miss arriving in the same cycle as the walk completion is born resolved.
    assign w_wr_match = i_mark_en
                     && (i_wr_data.addr[ADDR_W-1:PAGE_LSB] == i_mark_page)
                     && (i_wr_data.thread == i_mark_thread);

    // NOTE: only the control bits (valid/resolved/pointers) are reset; the payload
    // array is never read while its valid bit is clear, so it needs no reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= '0;
            r_resolved <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else if (i_flush) begin
            r_valid    <= '0;
            r_resolved <= '0;
            r_head     <= r_tail;
        end else begin
            if (i_mark_en) begin
                r_resolved <= r_resolved | w_match;
            end
            if (i_pop) begin
                r_valid[w_head_idx] <= 1'b0;
                r_head              <= r_head + PTR_W'(1);
            end
            if (i_wr_en) begin
                r_valid[w_tail_idx]    <= 1'b1;
                r_resolved[w_tail_idx] <= w_wr_match;
                r_tail                 <= r_tail + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[w_tail_idx] <= i_wr_data;
        end
    end

    assign o_count         = r_tail - r_head;
    assign o_any_valid     = |r_valid;
    assign o_head_valid    = r_valid[w_head_idx];
    assign o_head_resolved = r_resolved[w_head_idx];
    assign o_head          = r_data[w_head_idx];
    assign o_next_valid    = r_valid[w_next_idx];
    assign o_next_resolved = r_resolved[w_next_idx];
    assign o_next_addr     = r_data[w_next_idx].addr;
    assign o_next_attr     = r_data[w_next_idx].attr;

endmodule

// File: rtl/sagu_miss_sched.sv
// Store-AGU TLB-miss scheduler: buffers missed stores, walks each distinct page
// oldest-first and replays resolved ops into the AGU through the mex port.
module sagu_miss_sched
    import sagu_miss_sched_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              except,
    input  logic              miss_en,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic [ATTR_W-1:0] miss_attr,
    input  logic              miss_thread,
    output logic              walk_req,
    output logic [PAGE_W-1:0] walk_page,
    output logic              walk_thread,
    input  logic              walk_ack,
    input  logic              walk_done,
    output logic              issue_hold,
    output logic              mex_en,
    output logic [ADDR_W-1:0] mex_addr,
    output logic [ATTR_W-1:0] mex_attr,
    output logic              full,
    output logic              overflow,
    output logic              busy
);
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t            r_state;
    state_t            w_next;
    logic [TMR_W-1:0]  r_timer;
    logic              r_walk_req;
    logic [PAGE_W-1:0] r_walk_page;
    logic              r_walk_thread;
    logic              r_issue_hold;
    logic              r_mex_en;
    logic [ADDR_W-1:0] r_mex_addr;
    logic [ATTR_W-1:0] r_mex_attr;
    logic              r_overflow;

    logic [PTR_W-1:0]  w_count;
    logic              w_any_valid;
    logic              w_head_valid;
    logic              w_head_resolved;
    miss_data_t        w_head;
    logic              w_next_valid;
    logic              w_next_resolved;
    logic [ADDR_W-1:0] w_next_addr;
    logic [ATTR_W-1:0] w_next_attr;
    miss_data_t        w_wr_data;
    logic              w_wr_en;
    logic              w_drop;
    logic              w_pop;
    logic              w_mark_en;

    assign w_wr_data = '{addr: miss_addr, attr: miss_attr, thread: miss_thread};
    assign w_wr_en   = miss_en && !except && (w_count <  PTR_W'(DEPTH));
    assign w_drop    = miss_en && !except && (w_count == PTR_W'(DEPTH));
    assign w_pop     = (r_state == S_REPLAY) && !except;
    assign w_mark_en = (r_state == S_WALK_WAIT) && walk_done && !except;

    sagu_miss_buf #(.DEPTH(DEPTH)) u_buf (
        .clk             (clk),
        .rst             (rst),
        .i_flush         (except),
        .i_wr_en         (w_wr_en),
        .i_wr_data       (w_wr_data),
        .i_pop           (w_pop),
        .i_mark_en       (w_mark_en),
        .i_mark_page     (r_walk_page),
        .i_mark_thread   (r_walk_thread),
        .o_count         (w_count),
        .o_any_valid     (w_any_valid),
        .o_head_valid    (w_head_valid),
        .o_head_resolved (w_head_resolved),
        .o_head          (w_head),
        .o_next_valid    (w_next_valid),
        .o_next_resolved (w_next_resolved),
        .o_next_addr     (w_next_addr),
        .o_next_attr     (w_next_attr)
    );

    // NOTE: next-state is given a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (w_head_valid) w_next = w_head_resolved ? S_HOLD : S_WALK_REQ;
            S_WALK_REQ:  if (walk_ack) w_next = S_WALK_WAIT;
            S_WALK_WAIT: begin
                if (walk_done)                        w_next = S_HOLD;
                else if (r_timer == TMR_W'(TIMEOUT))  w_next = S_WALK_REQ;
            end
            S_HOLD:      w_next = S_REPLAY;
            S_REPLAY:    if (!(w_next_valid && w_next_resolved)) w_next = S_IDLE;
            S_DRAIN:     if (walk_done) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        // A walk the walker has already latched must be allowed to finish.
        if (except) begin
            if ((r_state == S_WALK_WAIT && !walk_done) || (r_state == S_WALK_REQ && walk_ack))
                w_next = S_DRAIN;
            else if (r_state != S_DRAIN)
                w_next = S_IDLE;
        end
    end

    // NOTE: every register here uses non-blocking assignment so all of them
    // update together from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_walk_req    <= 1'b0;
            r_walk_page   <= '0;
            r_walk_thread <= 1'b0;
            r_issue_hold  <= 1'b0;
            r_mex_en      <= 1'b0;
            r_mex_addr    <= '0;
            r_mex_attr    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_walk_req   <= (w_next == S_WALK_REQ);
            r_issue_hold <= (w_next == S_HOLD) || (w_next == S_REPLAY);
            r_mex_en     <= (w_next == S_REPLAY);
            r_overflow   <= w_drop;
            if (r_state == S_WALK_REQ && walk_ack)
                r_timer <= '0;
            else if (r_state == S_WALK_WAIT)
                r_timer <= r_timer + TMR_W'(1);
            if (r_state == S_IDLE && w_next == S_WALK_REQ) begin
                r_walk_page   <= w_head.addr[ADDR_W-1:PAGE_LSB];
                r_walk_thread <= w_head.thread;
            end
            // Replay data is the entry at the head once this cycle's pop has retired.
            if (w_next == S_REPLAY) begin
                r_mex_addr <= (r_state == S_REPLAY) ? w_next_addr : w_head.addr;
                r_mex_attr <= (r_state == S_REPLAY) ? w_next_attr : w_head.attr;
            end else begin
                r_mex_addr <= '0;
                r_mex_attr <= '0;
            end
        end
    end

    assign walk_req    = r_walk_req;
    assign walk_page   = r_walk_page;
    assign walk_thread = r_walk_thread;
    assign issue_hold  = r_issue_hold;
    assign mex_en      = r_mex_en;
    assign mex_addr    = r_mex_addr;
    assign mex_attr    = r_mex_attr;
    assign overflow    = r_overflow;
    assign full        = (w_count >= PTR_W'(DEPTH - 1));
    assign busy        = (r_state != S_IDLE) || w_any_valid;

endmodule
